// File: rtl/uart_burst_tx.sv
// Buffered UART transmitter: a small FIFO feeds a framing FSM that sends
// start, data (LSB first), optional parity, 1-2 stop bits and an idle gap.
module uart_burst_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int GAP_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_en,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic                  i_stop2,
    input  logic [GAP_WIDTH-1:0]  i_gap,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_frame_done,
    output logic                  o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [AW:0]           w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_head;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_par;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_stopcnt;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic [GAP_WIDTH-1:0]  r_gapcnt;
    logic                  r_tx;
    logic                  r_done;

    logic                  w_stop_end;
    logic                  w_gap_end;
    logic                  w_next;
    logic                  w_pop;
    logic                  w_wr_ok;

    assign w_head     = r_mem[r_rptr];
    assign w_stop_end = (r_state == S_STOP) && (!r_stop2 || r_stopcnt);
    assign w_gap_end  = (r_state == S_GAP) && (r_gapcnt == r_gap);
    assign w_next     = w_gap_end || (w_stop_end && (r_gap == '0));
    // Back-to-back frames pop straight out of stop/gap with no idle bit
    assign w_pop      = i_tick && !r_empty && ((r_state == S_IDLE) || w_next);
    assign w_wr_ok    = i_wr_en && (!r_full || w_pop);

    assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr_ok}
                                 - {{AW{1'b0}}, w_pop};

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == '0);
            if (i_wr_en && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_par     <= 1'b0;
            r_par_en  <= 1'b0;
            r_stop2   <= 1'b0;
            r_stopcnt <= 1'b0;
            r_gap     <= '0;
            r_gapcnt  <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        r_tx     <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= BW'(1);
                        r_state  <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bitcnt == BIT_LAST) begin
                            r_stopcnt <= 1'b0;
                            if (r_par_en) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end
                    end
                    S_PARITY: begin
                        r_tx      <= 1'b1;
                        r_stopcnt <= 1'b0;
                        r_state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (!w_stop_end) begin
                            r_stopcnt <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (r_gap != '0) begin
                                r_gapcnt <= GAP_WIDTH'(1);
                                r_state  <= S_GAP;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_gap_end) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gapcnt <= r_gapcnt + GAP_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
                // A pop overrides the branch above and starts a new frame
                if (w_pop) begin
                    r_shift  <= w_head;
                    r_par    <= (^w_head) ^ i_par_typ;
                    r_par_en <= i_par_en;
                    r_stop2  <= i_stop2;
                    r_gap    <= i_gap;
                    r_tx     <= 1'b0;
                    r_state  <= S_START;
                end
            end
        end
    end

    assign o_tx_out     = r_tx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_full       = r_full;
    assign o_empty      = r_empty;
    assign o_frame_done = r_done;
    assign o_overflow   = r_ovf;

endmodule

// File: doc/uart_burst_tx.md
UART_BURST_TX -- requirements
Module: uart_burst_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame, range 5..9.
REQ-002 Parameter DEPTH, default 4: frame buffer entries, a power of 2, 2..16.
REQ-003 Parameter GAP_WIDTH, default 4: width of the inter-frame gap count input.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 TICK  input  1  bit-rate strobe, one CLK cycle wide; each serial bit lasts exactly one TICK period.
REQ-007 WR_DATA  input  DATA_WIDTH  payload to enqueue.
REQ-008 WR_EN  input  1  enqueue strobe.
REQ-009 PAR_EN  input  1  1 = parity bit appended.
REQ-010 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-011 STOP2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-012 GAP  input  GAP_WIDTH  idle-high bit periods inserted after each frame.
REQ-013 TX_OUT  output  1  serial line, idle high, LSB first.
REQ-014 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-015 FULL  output  1  buffer holds DEPTH entries.
REQ-016 EMPTY  output  1  buffer holds 0 entries.
REQ-017 FRAME_DONE  output  1  one-CLK pulse at the TICK that ends the final stop bit.
REQ-018 OVERFLOW  output  1  sticky: a write was attempted while FULL.

Function
REQ-019 Buffer is a circular FIFO; the read and write pointers wrap modulo DEPTH; the count is held in log2(DEPTH)+1 bits.
REQ-020 A write is accepted when WR_EN=1 and FULL=0; a write with FULL=1 is dropped and sets OVERFLOW.
REQ-021 A pop on the same cycle as a write with FULL=1 frees a slot, so the write is accepted and the count is unchanged.
REQ-022 FULL and EMPTY are registered and update on the cycle after the pointer change.
REQ-023 FSM states: IDLE, START, DATA, PARITY, STOP, GAP; transitions occur only on cycles with TICK=1.
REQ-024 IDLE with TICK=1 and EMPTY=0: pop the head entry, latch PAR_EN, PAR_TYP, STOP2 and GAP for the frame, drive TX_OUT<=0, and go to START.
REQ-025 Changes to PAR_EN, PAR_TYP, STOP2 or GAP during a frame do not affect that frame.
REQ-026 START -> DATA on the next TICK, with TX_OUT <= bit 0.
REQ-027 DATA shifts out bits 1..DATA_WIDTH-1 on successive TICKs, using a bit counter of width log2(DATA_WIDTH)+1.
REQ-028 After the last data bit: PARITY if PAR_EN=1, otherwise STOP.
REQ-029 The parity bit is the XOR of all payload bits, inverted when PAR_TYP=1.
REQ-030 STOP drives TX_OUT=1 for 1 bit period, or 2 if STOP2=1.
REQ-031 At the TICK ending the final stop bit, FRAME_DONE=1 for one cycle; the FSM then goes to GAP if GAP>0, otherwise it follows REQ-032.
REQ-032 GAP holds TX_OUT=1 for GAP periods; at its end, or at stop end when GAP=0:
- EMPTY=0: start the next frame immediately (TX_OUT<=0, pop, go to START), with no extra idle bit.
- EMPTY=1: go to IDLE.
REQ-033 Frame length in TICKs is 1+DATA_WIDTH+PAR_EN+1+STOP2; with the defaults and PAR_EN=1, STOP2=0 it is 11.
REQ-034 A TICK received in IDLE with EMPTY=1 leaves TX_OUT=1 and the FSM in IDLE.
REQ-035 WR_EN is independent of TICK; writes are accepted during any state.

Reset
REQ-036 RST_N=0 asynchronously forces the following, including mid-frame:
- FSM to IDLE, pointers and count to 0;
- TX_OUT=1, BUSY=0, FULL=0, EMPTY=1, FRAME_DONE=0, OVERFLOW=0.
REQ-037 A frame aborted by reset is discarded; buffer contents are lost.
REQ-038 After reset is released, the first start bit requires a write followed by a TICK.

Verification
REQ-039 Write 0xAA, PAR_EN=1, PAR_TYP=0, STOP2=0, GAP=0 -> TX_OUT sequence 0,0,1,0,1,0,1,0,1,0,1 and one FRAME_DONE pulse.
REQ-040 Write 0x05, PAR_TYP=1 -> parity bit 1; write 0x77, PAR_TYP=0 -> parity bit 0.
REQ-041 Write 0xAA, 0x05, 0x77 back-to-back with GAP=0 -> 33 contiguous TICKs, no idle bit between frames, 3 FRAME_DONE pulses, then EMPTY=1 and BUSY=0.
REQ-042 With DEPTH=4 and no TICKs, write 5 entries -> FULL=1 after the 4th write, OVERFLOW=1 after the 5th, and the 5th payload is never transmitted.
REQ-043 PAR_EN=0, STOP2=1, GAP=3 with 2 entries -> 11 TICKs per frame plus 3 idle-high TICKs between frames.
REQ-044 Assert RST_N=0 during DATA bit 4 -> TX_OUT=1 immediately, EMPTY=1, and no FRAME_DONE pulse.
